div_by_five_result_serializer: RTL and testbench

Downstream stage of the divide-by-five unit. Captures the quotient and remainder in the single cycle the divider asserts its output-valid, then streams them as a fixed-length frame of narrow nibbles over a valid/ready interface toward the output pins. The divider has no output backpressure, so this block is the only point where a result can be held. A result that arrives while a frame is in flight is dropped and flagged.

---
 rtl/div_by_five_pkg.sv | 21 ++
 rtl/div_by_five_result_serializer.sv | 146 ++++++++++++++
 tb/tb_div_by_five_result_serializer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/div_by_five_pkg.sv
// -----------------------------------------------------------------------------
// div_by_five_pkg
// Definitions shared by the divide-by-five datapath: the two-state control
// encoding (also used by the divider control) and the default widths of the
// divider result.
// -----------------------------------------------------------------------------
package div_by_five_pkg;

  // Two-state control: waiting for a result, or streaming/computing one.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Default quotient width produced by the divider.
  localparam int DIV_DATA_W = 8;

  // Remainder of a divide by five is 0..4, so three bits.
  localparam int REM_W = 3;

endpackage : div_by_five_pkg

// File: rtl/div_by_five_result_serializer.sv
// -----------------------------------------------------------------------------
// div_by_five_result_serializer
// Captures a {quotient, remainder} result in the single cycle the divider
// flags it valid. The result is then streamed MSB-first as BEATS beats of
// OUT_W bits over a valid/ready link. The divider cannot be stalled, so a
// result that arrives mid-frame is dropped and recorded in a sticky overrun
// flag. The exception is a result that arrives on the last-beat transfer:
// that result is chained straight into the next frame.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   res_val    divider result valid (single-cycle pulse)
//   quotient   DATA_W-bit quotient, sampled with res_val
//   remainder  REM_W-bit remainder (0..4), sampled with res_val
//   nib_out    current OUT_W-bit beat
//   nib_val    beat valid
//   nib_rdy    consumer ready
//   nib_last   final beat of the frame
//   busy       frame in flight
//   overrun    sticky "result dropped" flag, cleared only by reset
// -----------------------------------------------------------------------------
module div_by_five_result_serializer
  import div_by_five_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int OUT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_val,
  input  logic [DATA_W-1:0] quotient,
  input  logic [REM_W-1:0]  remainder,
  output logic [OUT_W-1:0]  nib_out,
  output logic              nib_val,
  input  logic              nib_rdy,
  output logic              nib_last,
  output logic              busy,
  output logic              overrun
);

  localparam int BEATS   = DATA_W / OUT_W + 1;
  localparam int FRAME_W = DATA_W + OUT_W;
  localparam int CNT_W   = $clog2(BEATS);

  // Quotient in the upper beats, remainder zero-extended into the last beat.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [DATA_W-1:0] q,
    input logic [REM_W-1:0]  r
  );
    build_frame = (FRAME_W'(q) << OUT_W) | FRAME_W'(r);
  endfunction

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               overrun_q, overrun_d;

  logic               send_s;
  logic               last_s;
  logic               xfer_s;
  logic               last_xfer_s;

  // Outputs are decoded only from state, counter and shift register, so
  // nib_val never has a combinational path from nib_rdy.
  always_comb begin
    send_s      = (state_q == SEND);
    last_s      = send_s && (cnt_q == CNT_W'(BEATS - 1));
    xfer_s      = send_s && nib_rdy;
    last_xfer_s = xfer_s && last_s;
  end

  assign nib_val  = send_s;
  assign busy     = send_s;
  assign nib_last = last_s;
  // The frame is fully shifted out by the time the block returns to IDLE,
  // so this reads zero whenever nothing is being sent.
  assign nib_out  = shift_q[FRAME_W-1 -: OUT_W];
  assign overrun  = overrun_q;

  // Next-state logic: capture, shift on handshake, chain or drop new results.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (res_val) begin
          shift_d = build_frame(quotient, remainder);
          cnt_d   = '0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (last_xfer_s) begin
          if (res_val) begin
            // Back-to-back result: reload with no idle bubble.
            shift_d = build_frame(quotient, remainder);
            cnt_d   = '0;
            state_d = SEND;
          end else begin
            shift_d = shift_q << OUT_W;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          if (xfer_s) begin
            shift_d = shift_q << OUT_W;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
          end
          // No place to hold a second result: drop it, keep the frame.
          if (res_val) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

endmodule : div_by_five_result_serializer

// File: tb/tb_div_by_five_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_div_by_five_result_serializer
// Directed scenarios followed by random traffic, all checked against a
// queue-based model of the frame stream (DATA_W = 8, OUT_W = 4, BEATS = 3).
// -----------------------------------------------------------------------------
module tb_div_by_five_result_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       res_val;
  logic [7:0] quotient;
  logic [2:0] remainder;
  logic [3:0] nib_out;
  logic       nib_val;
  logic       nib_rdy;
  logic       nib_last;
  logic       busy;
  logic       overrun;

  int n_pass  = 0;
  int n_total = 0;

  // Model: beats still to be sent for the frame in flight, and the flag.
  int beats_q[$];
  bit m_overrun;
  bit m_just_reset;

  div_by_five_result_serializer #(.DATA_W(8), .OUT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_val   (res_val),
    .quotient  (quotient),
    .remainder (remainder),
    .nib_out   (nib_out),
    .nib_val   (nib_val),
    .nib_rdy   (nib_rdy),
    .nib_last  (nib_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Frame value is q*16 + r; beats are its nibbles, most significant first.
  task automatic push_frame(input int q, input int r);
    int frame;
    frame = q * 16 + r;
    for (int k = 2; k >= 0; k--) beats_q.push_back((frame >> (4 * k)) & 15);
  endtask

  // One clock cycle: drive inputs, check current outputs, advance the model.
  task automatic step(input bit rst, input bit res, input int q, input int r,
                      input bit rdy, input string tag);
    bit in_flight;
    bit xfer;
    bit last_xfer;
    @(negedge clk);
    rst_n     = rst;
    res_val   = res;
    quotient  = 8'(q);
    remainder = 3'(r);
    nib_rdy   = rdy;
    #1;
    in_flight = (beats_q.size() > 0);
    chk({tag, ".nib_val"},  int'(nib_val),  int'(in_flight));
    chk({tag, ".busy"},     int'(busy),     int'(in_flight));
    chk({tag, ".overrun"},  int'(overrun),  int'(m_overrun));
    chk({tag, ".nib_last"}, int'(nib_last), int'(beats_q.size() == 1));
    if (in_flight)    chk({tag, ".nib_out"}, int'(nib_out), beats_q[0]);
    if (m_just_reset) chk({tag, ".rst_nib_out"}, int'(nib_out), 0);
    // Model update for the coming rising edge.
    if (!rst) begin
      beats_q.delete();
      m_overrun    = 1'b0;
      m_just_reset = 1'b1;
    end else begin
      m_just_reset = 1'b0;
      xfer      = in_flight && rdy;
      last_xfer = xfer && (beats_q.size() == 1);
      if (xfer) void'(beats_q.pop_front());
      if (res) begin
        if (!in_flight || last_xfer) push_frame(q, r);
        else m_overrun = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    int q;
    int r;
    rst_n = 1'b0; res_val = 1'b0; quotient = '0; remainder = '0; nib_rdy = 1'b0;
    beats_q.delete();
    m_overrun    = 1'b0;
    m_just_reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, then reset/capture collision: nothing may be captured.
    step(1'b0, 1'b1, 8'h55, 3, 1'b1, "collide");
    step(1'b1, 1'b0, 0, 0, 1'b1, "collide_after");
    step(1'b1, 1'b0, 0, 0, 1'b1, "collide_idle");

    // Basic frame 9/2 with nib_rdy held high: 0x0, 0x9, 0x2.
    step(1'b1, 1'b1, 9, 2, 1'b1, "basic_load");
    repeat (3) step(1'b1, 1'b0, 0, 0, 1'b1, "basic_beat");
    step(1'b1, 1'b0, 0, 0, 1'b1, "basic_idle");

    // Backpressure: 0xA7/4, stall three cycles on beat 0x7.
    step(1'b1, 1'b1, 8'hA7, 4, 1'b1, "bp_load");
    step(1'b1, 1'b0, 0, 0, 1'b1, "bp_beat0");
    repeat (3) step(1'b1, 1'b0, 0, 0, 1'b0, "bp_stall");
    repeat (2) step(1'b1, 1'b0, 0, 0, 1'b1, "bp_beat");
    step(1'b1, 1'b0, 0, 0, 1'b1, "bp_idle");

    // Back-to-back: 0x33/1 arrives on the last-beat transfer of 9/2.
    step(1'b1, 1'b1, 9, 2, 1'b1, "b2b_load");
    repeat (2) step(1'b1, 1'b0, 0, 0, 1'b1, "b2b_beat");
    step(1'b1, 1'b1, 8'h33, 1, 1'b1, "b2b_chain");
    repeat (3) step(1'b1, 1'b0, 0, 0, 1'b1, "b2b_second");
    step(1'b1, 1'b0, 0, 0, 1'b1, "b2b_idle");

    // Overrun: 0xFF/0 arrives during the first beat of 9/2.
    step(1'b1, 1'b1, 9, 2, 1'b1, "ovr_load");
    step(1'b1, 1'b1, 8'hFF, 0, 1'b1, "ovr_drop");
    repeat (2) step(1'b1, 1'b0, 0, 0, 1'b1, "ovr_beat");
    step(1'b1, 1'b1, 8'h12, 3, 1'b1, "ovr_next");
    repeat (4) step(1'b1, 1'b0, 0, 0, 1'b1, "ovr_sticky");

    // Reset mid-frame after the first beat transfers, then a fresh frame.
    step(1'b1, 1'b1, 8'h6C, 4, 1'b1, "rstmid_load");
    step(1'b1, 1'b0, 0, 0, 1'b1, "rstmid_beat0");
    step(1'b0, 1'b0, 0, 0, 1'b1, "rstmid_rst");
    step(1'b1, 1'b1, 8'h9D, 1, 1'b1, "rstmid_new");
    repeat (4) step(1'b1, 1'b0, 0, 0, 1'b1, "rstmid_frame");

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      q = int'($urandom_range(0, 255));
      r = int'($urandom_range(0, 4));
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0), q, r,
           ($urandom_range(0, 2) != 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_div_by_five_result_serializer
